// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter among
// NUM_REQ byte-stream requesters using a start/busy handshake.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int LOCK_TIMEOUT = 1000000,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [IDW-1:0]                grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int CW = IDW + 1;
  localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    WAIT_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDW-1:0]          owner;
  logic [IDW-1:0]          last_grant;
  logic [IDW-1:0]          pick_idx;
  logic                    pick_found;
  logic [CW-1:0]           cand;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    last_flag;
  logic [TW-1:0]           timer;
  logic                    xfer;
  logic                    timeout_hit;

  // Search from the requester after the last winner, wrapping around, so the
  // previous owner ends up with the lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!pick_found && req_valid[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDW'(i)) begin
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer        = (state == GRANT) && !tx_busy && req_valid[owner];
  assign timeout_hit = (LOCK_TIMEOUT != 0) && (state == GRANT) && !xfer &&
                       (timer == TIMEOUT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    tx_start    = 1'b0;
    active      = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        active           = 1'b1;
        req_ready[owner] = !tx_busy;
        if (xfer) begin
          state_nxt = SEND;
        end else if (timeout_hit) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      SEND: begin
        active   = 1'b1;
        tx_start = 1'b1;
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        active = 1'b1;
        if (!tx_busy) begin
          state_nxt = last_flag ? IDLE : GRANT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The lock timer only runs while the owner is in GRANT with nothing to offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      tx_data_q  <= '0;
      last_flag  <= 1'b0;
      timer      <= '0;
    end else begin
      if ((state == IDLE) && pick_found) begin
        owner <= pick_idx;
      end
      if (xfer) begin
        tx_data_q <= owner_data;
        last_flag <= req_last[owner];
      end
      if ((state != GRANT) || xfer || timeout_hit) begin
        timer <= '0;
      end else if ((LOCK_TIMEOUT != 0) && !req_valid[owner] &&
                   (timer != TIMEOUT_VAL)) begin
        timer <= timer + 1'b1;
      end
      if (timeout_hit ||
          ((state == WAIT_DONE) && !tx_busy && last_flag)) begin
        last_grant <= owner;
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = owner;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (tx_start && !tx_busy) |=> $stable(tx_data));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model that logs
// every accepted byte together with the grant that sent it.
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int DW       = 8;
  localparam int LT       = 16;
  localparam int BUSY_LEN = 10;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic [NR-1:0]     req_valid  = '0;
  logic [NR*DW-1:0]  req_data   = '0;
  logic [NR-1:0]     req_last   = '0;
  logic [NR-1:0]     req_ready;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy;
  logic [1:0]        grant_id;
  logic              active;
  logic              timeout_err;

  logic              uart_busy  = 1'b0;
  logic              force_busy = 1'b0;
  int                busy_cnt   = 0;
  logic [DW-1:0]     sent_q[$];
  logic [1:0]        gid_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  assign tx_busy = uart_busy | force_busy;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // UART model: accepts a start while idle, then stays busy for BUSY_LEN cycles.
  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) uart_busy <= 1'b0;
    end else if (tx_start && !uart_busy) begin
      uart_busy <= 1'b1;
      busy_cnt  <= BUSY_LEN;
      sent_q.push_back(tx_data);
      gid_q.push_back(grant_id);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_byte(input int r, input logic [DW-1:0] b, input logic l);
    req_data[r*DW +: DW] = b;
    req_last[r]          = l;
  endtask

  task automatic wait_inactive(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    force_busy = 1'b0;
    for (int c = 0; c < 300 && uart_busy; c++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sent_q.delete();
    gid_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({req_ready, tx_start, tx_data, grant_id, active, timeout_err} !== 17'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {req_ready, tx_start, tx_data, grant_id, active, timeout_err});
    end
    @(negedge clk);
    n_checks++;
    if (active !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: active=%b ready=%b expected 0/0000", active, req_ready);
    end
  endtask

  task automatic test_single_byte();
    bit ok;
    do_reset();
    set_byte(2, 8'h41, 1'b1);
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant_id !== 2'd2 || active !== 1'b1 || req_ready !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL single_grant: grant=%0d active=%b ready=%b expected 2/1/0100",
               grant_id, active, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h41 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_start: start=%b data=%h ready=%b expected 1/41/0000",
               tx_start, tx_data, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b0 || active !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_start_drop: start=%b active=%b expected 0/1", tx_start, active);
    end
    repeat (9) @(negedge clk);
    n_checks++;
    if (active !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_done_detect: active=%b busy=%b expected 1/0", active, tx_busy);
    end
    @(negedge clk);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_release: active=%b expected 0", active);
    end
    wait_inactive(ok);
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_g[5];
    logic [DW-1:0] exp_d[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    for (int r = 0; r < NR; r++) set_byte(r, DW'(8'h10 + r), 1'b1);
    req_valid = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sent_q.size() >= 5) break;
    end
    req_valid = '0;
    wait_inactive(ok);
    n_checks++;
    if (!ok || sent_q.size() != 5) begin
      n_fail++;
      $display("[TB] FAIL rr_count: bytes=%0d idle=%b expected 5/1", sent_q.size(), ok);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (gid_q[i] !== 2'(exp_g[i]) || sent_q[i] !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL rr_order[%0d]: grant=%0d data=%h expected %0d/%h",
                 i, gid_q[i], sent_q[i], exp_g[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_packet_lock();
    bit ok;
    bit pend;
    int idx;
    logic [DW-1:0] msg[3];
    logic [DW-1:0] exp_d[4];
    int exp_g[4];
    msg   = '{8'h48, 8'h49, 8'h0A};
    exp_d = '{8'h48, 8'h49, 8'h0A, 8'h33};
    exp_g = '{1, 1, 1, 3};
    do_reset();
    set_byte(1, msg[0], 1'b0);
    set_byte(3, 8'h33, 1'b1);
    req_valid = 4'b1010;
    idx  = 0;
    pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (pend) begin
        idx++;
        if (idx < 3) set_byte(1, msg[idx], idx == 2);
        else req_valid[1] = 1'b0;
      end
      if (sent_q.size() >= 4) begin
        req_valid[3] = 1'b0;
        break;
      end
      pend = req_valid[1] && req_ready[1];
    end
    req_valid = '0;
    wait_inactive(ok);
    n_checks++;
    if (!ok || sent_q.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL lock_count: bytes=%0d idle=%b expected 4/1", sent_q.size(), ok);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (gid_q[i] !== 2'(exp_g[i]) || sent_q[i] !== exp_d[i]) begin
        n_fail++;
        $display("[TB] FAIL lock_order[%0d]: grant=%0d data=%h expected %0d/%h",
                 i, gid_q[i], sent_q[i], exp_g[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    do_reset();
    set_byte(0, 8'h55, 1'b0);
    set_byte(1, 8'h66, 1'b1);
    req_valid = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant_id !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL to_first_byte: start=%b data=%h grant=%0d expected 1/55/0",
               tx_start, tx_data, grant_id);
    end
    req_valid[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL to_regrant: ready0=%b expected 1", req_ready[0]);
    end
    early = 1'b0;
    for (int k = 1; k < LT; k++) begin
      @(negedge clk);
      if (timeout_err) early = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (early || timeout_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL to_pulse: early=%b err=%b expected 0/1", early, timeout_err);
    end
    @(negedge clk);
    n_checks++;
    if (active !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL to_release: active=%b err=%b expected 0/0", active, timeout_err);
    end
    @(negedge clk);
    n_checks++;
    if (active !== 1'b1 || grant_id !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL to_next_grant: active=%b grant=%0d expected 1/1", active, grant_id);
    end
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sent_q.size() >= 2) req_valid = '0;
      if (!active && sent_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || sent_q.size() != 2 || sent_q[1] !== 8'h66) begin
      n_fail++;
      $display("[TB] FAIL to_second_owner: bytes=%0d last=%h expected 2/66",
               sent_q.size(), sent_q[sent_q.size()-1]);
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    bit early;
    do_reset();
    force_busy = 1'b1;
    set_byte(0, 8'h77, 1'b1);
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant_id !== 2'd0 || active !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL busy_grant: grant=%0d active=%b ready=%b expected 0/1/0000",
               grant_id, active, req_ready);
    end
    early = 1'b0;
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || tx_start !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("[TB] FAIL busy_no_early: early=%b expected 0", early);
    end
    force_busy = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL busy_ready_after: ready=%b expected 0001", req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h77) begin
      n_fail++;
      $display("[TB] FAIL busy_start: start=%b data=%h expected 1/77", tx_start, tx_data);
    end
    req_valid = '0;
    wait_inactive(ok);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int base;
    do_reset();
    set_byte(1, 8'hA1, 1'b0);
    req_valid = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    for (int c = 0; c < 50 && ok; c++) begin
      @(negedge clk);
      if (!tx_start) break;
    end
    n_checks++;
    if (!ok || active !== 1'b1 || tx_start !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_wait_done: seen=%b active=%b start=%b busy=%b expected 1/1/0/1",
               ok, active, tx_start, tx_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, tx_start, tx_data, grant_id, active, timeout_err} !== 17'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_async_outputs: got %h expected 0",
               {req_ready, tx_start, tx_data, grant_id, active, timeout_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = sent_q.size();
    set_byte(0, 8'hB0, 1'b1);
    req_valid = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (grant_id !== 2'd0 || active !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL rst_regrant: grant=%0d active=%b ready=%b expected 0/1/0000",
               grant_id, active, req_ready);
    end
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sent_q.size() > base) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = '0;
    n_checks++;
    if (!ok || sent_q[base] !== 8'hB0 || gid_q[base] !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_first_byte: seen=%b data=%h grant=%0d expected 1/B0/0",
               ok, sent_q[base], gid_q[base]);
    end
    wait_inactive(ok);
  endtask

  initial begin
    $display("[TB] starting uart_tx_arbiter bench");
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_busy_hold();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
